// File: rtl/pixel_seq_pkg.sv
// Shared types and constants for the pixel frame sequencer.
package pixel_seq_pkg;

  // Frame sequencing states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    SETTLE,
    CONVERT,
    NEXT,
    FRAME_END
  } state_t;

  // Shortest exposure the sequencer will run; a programmed 0 is raised to this.
  localparam int unsigned MIN_EXPOSURE = 1;

endpackage : pixel_seq_pkg

// File: rtl/row_decoder.sv
// Binary row address to one-hot row enable, gated by an enable.
module row_decoder #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned ROW_W = $clog2(ROWS)
) (
  input  logic             en,
  input  logic [ROW_W-1:0] addr,
  output logic [ROWS-1:0]  onehot
);

  // One bit per row; all zero when disabled or the address is out of range.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      onehot[i] = en && (addr == ROW_W'(i));
    end
  end

endmodule : row_decoder

// File: rtl/pixel_frame_sequencer.sv
// Frame sequencer: global erase, timed exposure, then row-by-row readout
// through the row decoder and the column ADC start/done handshake.
module pixel_frame_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int unsigned ROWS          = 4,
  parameter int unsigned ROW_W         = $clog2(ROWS),
  parameter int unsigned EXP_W         = 16,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned FCNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic [EXP_W-1:0]  exposure_cycles,
  input  logic              adc_done,
  output logic              erase,
  output logic              expose,
  output logic              bias_en,
  output logic [ROWS-1:0]   row_select,
  output logic [ROW_W-1:0]  row_addr,
  output logic              adc_start,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [EXP_W-1:0]  EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0]  EXP_MIN  = EXP_W'(MIN_EXPOSURE);
  localparam logic [SET_W-1:0]  SET_ONE  = SET_W'(1);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [FCNT_W-1:0] FC_ONE   = FCNT_W'(1);

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_addr_q, row_addr_d;
  logic [EXP_W-1:0]    exp_len_q, exp_len_d;
  logic [EXP_W-1:0]    exp_cnt_q, exp_cnt_d;
  logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

  logic                erase_q, expose_q, adc_start_q, busy_q, frame_done_q;
  logic [ROWS-1:0]     row_sel_q, row_sel_d;
  logic                row_en_d;

  // Next-state, row address, counters and frame count.
  always_comb begin
    state_d    = state_q;
    row_addr_d = row_addr_q;
    exp_len_d  = exp_len_q;
    exp_cnt_d  = '0;
    set_cnt_d  = '0;
    fcnt_d     = fcnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_len_d  = (exposure_cycles < EXP_MIN) ? EXP_MIN : exposure_cycles;
          row_addr_d = '0;
          state_d    = ERASE;
        end
      end
      ERASE: state_d = EXPOSE;
      EXPOSE: begin
        // Compare against exp_len-1 so the counter never has to hold exp_len.
        if (exp_cnt_q == (exp_len_q - EXP_ONE)) state_d = SETTLE;
        else                                    exp_cnt_d = exp_cnt_q + EXP_ONE;
      end
      SETTLE: begin
        if (set_cnt_q == SET_LAST) state_d = CONVERT;
        else                       set_cnt_d = set_cnt_q + SET_ONE;
      end
      CONVERT: begin
        if (adc_done) state_d = NEXT;
      end
      NEXT: begin
        if (row_addr_q == ROW_LAST) begin
          state_d = FRAME_END;
        end else begin
          row_addr_d = row_addr_q + ROW_ONE;
          state_d    = SETTLE;
        end
      end
      FRAME_END: begin
        // The count commits on leaving FRAME_END so an abort here drops it.
        fcnt_d = fcnt_q + FC_ONE;
        if (continuous) begin
          row_addr_d = '0;
          state_d    = ERASE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      row_addr_d = '0;
      exp_cnt_d  = '0;
      set_cnt_d  = '0;
      fcnt_d     = fcnt_q;
    end
  end

  // Outputs are registered from the next state, so they switch on the entering edge.
  assign row_en_d = (state_d == SETTLE) || (state_d == CONVERT);

  row_decoder #(
    .ROWS  (ROWS),
    .ROW_W (ROW_W)
  ) u_row_decoder (
    .en     (row_en_d),
    .addr   (row_addr_d),
    .onehot (row_sel_d)
  );

  // State, row address, exposure latch and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_addr_q <= '0;
      exp_len_q  <= '0;
      exp_cnt_q  <= '0;
      set_cnt_q  <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_addr_q <= row_addr_d;
      exp_len_q  <= exp_len_d;
      exp_cnt_q  <= exp_cnt_d;
      set_cnt_q  <= set_cnt_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Registered output decode of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      adc_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      row_sel_q    <= '0;
    end else begin
      erase_q      <= (state_d == ERASE);
      expose_q     <= (state_d == EXPOSE);
      adc_start_q  <= (state_d == CONVERT);
      busy_q       <= (state_d != IDLE);
      frame_done_q <= (state_d == FRAME_END);
      row_sel_q    <= row_sel_d;
    end
  end

  assign erase       = erase_q;
  assign expose      = expose_q;
  assign bias_en     = expose_q;
  assign row_select  = row_sel_q;
  assign row_addr    = row_addr_q;
  assign adc_start   = adc_start_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = fcnt_q;

endmodule : pixel_frame_sequencer

// File: tb/tb_pixel_frame_sequencer.sv
// Directed bench for pixel_frame_sequencer with a row/frame-done scoreboard.
module tb_pixel_frame_sequencer;

  localparam int ROWS   = 4;
  localparam int ROW_W  = 2;
  localparam int EXP_W  = 16;
  localparam int SETTLE = 2;
  localparam int FCNT_W = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic              continuous;
  logic              abort;
  logic [EXP_W-1:0]  exposure_cycles;
  logic              adc_done;
  logic              erase, expose, bias_en, adc_start, busy, frame_done;
  logic [ROWS-1:0]   row_select;
  logic [ROW_W-1:0]  row_addr;
  logic [FCNT_W-1:0] frame_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;
  logic [7:0] exp_fc = '0;
  logic [ROWS-1:0] prev_rs = '0;

  logic [ROWS-1:0] rs_q[$];
  int              done_q[$];

  pixel_frame_sequencer #(
    .ROWS          (ROWS),
    .ROW_W         (ROW_W),
    .EXP_W         (EXP_W),
    .SETTLE_CYCLES (SETTLE),
    .FCNT_W        (FCNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .continuous      (continuous),
    .abort           (abort),
    .exposure_cycles (exposure_cycles),
    .adc_done        (adc_done),
    .erase           (erase),
    .expose          (expose),
    .bias_en         (bias_en),
    .row_select      (row_select),
    .row_addr        (row_addr),
    .adc_start       (adc_start),
    .busy            (busy),
    .frame_done      (frame_done),
    .frame_count     (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to time events relative to a start edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string p);
    chk({p, "_erase"},      32'(erase),      0);
    chk({p, "_expose"},     32'(expose),     0);
    chk({p, "_bias"},       32'(bias_en),    0);
    chk({p, "_row_select"}, 32'(row_select), 0);
    chk({p, "_row_addr"},   32'(row_addr),   0);
    chk({p, "_adc_start"},  32'(adc_start),  0);
    chk({p, "_busy"},       32'(busy),       0);
    chk({p, "_frame_done"}, 32'(frame_done), 0);
  endtask

  // Leaves the caller at the falling edge of relative cycle k (cycle 1 = ERASE).
  task automatic at_cycle(input int k);
    while (cyc - t0 + 1 < k) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  // Pulse start and push the expected row sequence and frame_done cycles.
  task automatic start_frame(input int e, input int nfr, input int extra);
    int len;
    len = 2 + ((e == 0) ? 1 : e) + ROWS * (SETTLE + 2);
    exposure_cycles = EXP_W'(e);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
    for (int f = 1; f <= nfr; f++) begin
      for (int r = 0; r < ROWS; r++) rs_q.push_back(ROWS'(1 << r));
      done_q.push_back(f * len + extra);
    end
  endtask

  task automatic flush();
    rs_q.delete();
    done_q.delete();
  endtask

  // Scoreboard monitor: row_select transitions and frame_done timing.
  always @(negedge clk) begin
    if (!reset) begin
      if (row_select != '0 && row_select != prev_rs) begin
        if (rs_q.size() == 0) chk("row_unexpected", 32'(row_select), 0);
        else                  chk("row_seq", 32'(row_select), 32'(rs_q.pop_front()));
      end
      prev_rs = row_select;
      if (frame_done) begin
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else                    chk("done_cycle", 32'(cyc - t0 + 1), 32'(done_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k_wrap;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    exposure_cycles = '0; adc_done = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("rst");
    chk("rst_fcnt", 32'(frame_count), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single frame, exposure 3.
    start_frame(3, 1, 0);
    at_cycle(1);  chk("t1_erase", 32'(erase), 1); chk("t1_busy", 32'(busy), 1); chk("t1_exp0", 32'(expose), 0);
    at_cycle(2);  chk("t1_expose2", 32'(expose), 1); chk("t1_bias2", 32'(bias_en), 1);
    at_cycle(4);  chk("t1_expose4", 32'(expose), 1);
    at_cycle(5);  chk("t1_expose5", 32'(expose), 0); chk("t1_erase5", 32'(erase), 0); chk("t1_addr5", 32'(row_addr), 0);
    at_cycle(7);  chk("t1_adc7", 32'(adc_start), 1);
    at_cycle(21); chk("t1_done", 32'(frame_done), 1);
    at_cycle(22); chk("t1_idle", 32'(busy), 0); chk("t1_done_pulse", 32'(frame_done), 0);
    exp_fc++;     chk("t1_fcnt", 32'(frame_count), 32'(exp_fc));

    // ADC stall on row 2 for 10 CONVERT cycles.
    start_frame(3, 1, 9);
    at_cycle(13); adc_done = 1'b0;
    for (int k = 15; k <= 24; k++) begin
      at_cycle(k);
      chk("t2_adc_hold", 32'(adc_start), 1);
      chk("t2_rs_hold", 32'(row_select), 32'h4);
      chk("t2_addr_hold", 32'(row_addr), 2);
      if (k == 24) adc_done = 1'b1;
    end
    at_cycle(25); chk("t2_next_rs", 32'(row_select), 0); chk("t2_next_adc", 32'(adc_start), 0); chk("t2_next_addr", 32'(row_addr), 2);
    at_cycle(26); chk("t2_addr_adv", 32'(row_addr), 3);
    at_cycle(31); chk("t2_idle", 32'(busy), 0);
    exp_fc++;     chk("t2_fcnt", 32'(frame_count), 32'(exp_fc));

    // Stray adc_done in EXPOSE, start during CONVERT.
    adc_done = 1'b0;
    start_frame(5, 1, 0);
    at_cycle(3);  adc_done = 1'b1;
    at_cycle(5);  adc_done = 1'b0;
    at_cycle(6);  chk("t3_expose6", 32'(expose), 1);
    at_cycle(7);  chk("t3_expose7", 32'(expose), 0); chk("t3_adc7", 32'(adc_start), 0);
    at_cycle(9);  chk("t3_adc9", 32'(adc_start), 1); start = 1'b1; adc_done = 1'b1;
    at_cycle(10); start = 1'b0; chk("t3_busy10", 32'(busy), 1); chk("t3_erase10", 32'(erase), 0);
    at_cycle(24); chk("t3_idle", 32'(busy), 0); chk("t3_no_restart", 32'(erase), 0);
    exp_fc++;     chk("t3_fcnt", 32'(frame_count), 32'(exp_fc));

    // Exposure 0 behaves as 1.
    start_frame(0, 1, 0);
    at_cycle(2);  chk("t4_expose2", 32'(expose), 1);
    at_cycle(3);  chk("t4_expose3", 32'(expose), 0); chk("t4_rs3", 32'(row_select), 1);
    at_cycle(20); chk("t4_idle", 32'(busy), 0);
    exp_fc++;     chk("t4_fcnt", 32'(frame_count), 32'(exp_fc));

    // Continuous mode, three frames.
    continuous = 1'b1;
    start_frame(3, 3, 0);
    at_cycle(22); chk("t5_erase22", 32'(erase), 1); chk("t5_busy22", 32'(busy), 1);
    at_cycle(43); chk("t5_erase43", 32'(erase), 1);
    continuous = 1'b0;
    at_cycle(64); chk("t5_idle", 32'(busy), 0); chk("t5_erase64", 32'(erase), 0);
    exp_fc += 8'd3; chk("t5_fcnt", 32'(frame_count), 32'(exp_fc));

    // Abort during EXPOSE.
    start_frame(10, 1, 0);
    at_cycle(4);  abort = 1'b1;
    at_cycle(5);  abort = 1'b0; check_quiet("t6a"); chk("t6a_fcnt", 32'(frame_count), 32'(exp_fc));
    flush();

    // Abort during a stalled CONVERT.
    adc_done = 1'b0;
    start_frame(3, 1, 0);
    at_cycle(7);  chk("t6b_adc7", 32'(adc_start), 1);
    at_cycle(8);  chk("t6b_adc8", 32'(adc_start), 1); chk("t6b_rs8", 32'(row_select), 1); abort = 1'b1;
    at_cycle(9);  abort = 1'b0; check_quiet("t6b"); chk("t6b_fcnt", 32'(frame_count), 32'(exp_fc));
    flush();
    adc_done = 1'b1;

    // Abort and start together in IDLE.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_quiet("t6c");

    // Full frame after aborts.
    start_frame(3, 1, 0);
    at_cycle(22); chk("t6d_idle", 32'(busy), 0);
    exp_fc++;     chk("t6d_fcnt", 32'(frame_count), 32'(exp_fc));

    // Abort coinciding with FRAME_END.
    start_frame(3, 1, 0);
    at_cycle(21); chk("t6e_done", 32'(frame_done), 1); abort = 1'b1;
    at_cycle(22); abort = 1'b0; check_quiet("t6e"); chk("t6e_fcnt", 32'(frame_count), 32'(exp_fc));

    // frame_count wraps 255 -> 0.
    k_wrap = 256 - int'(exp_fc);
    continuous = 1'b1;
    start_frame(0, k_wrap, 0);
    at_cycle((k_wrap - 1) * 19 + 1);
    chk("t7_fcnt255", 32'(frame_count), 255);
    continuous = 1'b0;
    at_cycle(k_wrap * 19 + 1);
    chk("t7_idle", 32'(busy), 0);
    exp_fc = '0;
    chk("t7_fcnt_wrap", 32'(frame_count), 32'(exp_fc));

    // Asynchronous reset between clock edges in SETTLE.
    start_frame(3, 1, 0);
    at_cycle(5);
    chk("t8_settle_rs", 32'(row_select), 1);
    #2 reset = 1'b1;
    #1;
    check_quiet("t8");
    chk("t8_fcnt", 32'(frame_count), 0);
    flush();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_frame(3, 1, 0);
    at_cycle(22); chk("t8_idle", 32'(busy), 0);
    exp_fc++;     chk("t8_fcnt_after", 32'(frame_count), 32'(exp_fc));

    chk("rows_left", 32'(rs_q.size()), 0);
    chk("done_left", 32'(done_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pixel_frame_sequencer
